// File: rtl/ram_stream_reader_pkg.sv
// Shared definitions for the RAM burst stream reader: default widths and the
// two-bit FSM state encoding.
package ram_stream_reader_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_ADDR  = 2'd1;
  localparam state_t S_LATCH = 2'd2;
  localparam state_t S_VALID = 2'd3;

endpackage

// File: rtl/ram_stream_reader_if.sv
// Control, RAM read and stream signals of the reader, bundled into a single
// interface. The master side is the reader; the slave side is its environment.
interface ram_stream_reader_if
  import ram_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic                  start;
  logic                  abort;
  logic [ADDR_WIDTH-1:0] first_addr;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_data;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic                  out_valid;
  logic                  out_ready;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, abort, first_addr, last_addr, ram_data, out_ready,
    output ram_addr, out_data, out_addr, out_valid, busy, done
  );

  modport slave (
    output start, abort, first_addr, last_addr, ram_data, out_ready,
    input  ram_addr, out_data, out_addr, out_valid, busy, done
  );

endinterface

// File: rtl/dual_port_RAM.sv
// Simple dual-port RAM: one synchronous write port and one registered read
// port (data_out reflects read_addr sampled at the previous rising edge).
module dual_port_RAM #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (write_en) mem[write_addr] <= data_in;
    data_out <= mem[read_addr];
  end

endmodule

// File: rtl/ram_stream_reader.sv
// Reads an inclusive, wrapping address range from a registered-read RAM and
// streams each word with its address over a valid/ready handshake.
//
// state   | meaning
// IDLE    | waiting for start; start/first/last sampled here only
// ADDR    | ram_addr presented, RAM samples it at the next edge
// LATCH   | RAM output settling; registered into out_data at exit
// VALID   | word offered; held until out_ready or abort
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input logic                clk,
  input logic                rst_n,
  ram_stream_reader_if.master bus
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-1:0] end_addr;

  assign bus.busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cur_addr      <= '0;
      end_addr      <= '0;
      bus.ram_addr  <= '0;
      bus.out_data  <= '0;
      bus.out_addr  <= '0;
      bus.out_valid <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            cur_addr     <= bus.first_addr;
            end_addr     <= bus.last_addr;
            bus.ram_addr <= bus.first_addr;
            state        <= S_ADDR;
          end
        end
        S_ADDR: begin
          state <= bus.abort ? S_IDLE : S_LATCH;
        end
        S_LATCH: begin
          if (bus.abort) begin
            state <= S_IDLE;
          end else begin
            bus.out_data  <= bus.ram_data;
            bus.out_addr  <= cur_addr;
            bus.out_valid <= 1'b1;
            state         <= S_VALID;
          end
        end
        S_VALID: begin
          // abort wins over a transfer offered on the same edge
          if (bus.abort) begin
            bus.out_valid <= 1'b0;
            state         <= S_IDLE;
          end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            if (cur_addr == end_addr) begin
              bus.done <= 1'b1;
              state    <= S_IDLE;
            end else begin
              cur_addr     <= cur_addr + 1'b1;
              bus.ram_addr <= cur_addr + 1'b1;
              state        <= S_ADDR;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Scoreboard bench for ram_stream_reader beside a dual_port_RAM: bursts push
// their expected words, a negedge monitor pops and compares every transfer.
module tb_ram_stream_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       we = 1'b0;
  logic [3:0] waddr = '0;
  logic [7:0] wdata = '0;

  always #5 clk = ~clk;

  ram_stream_reader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  ram_stream_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  dual_port_RAM #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) ram (
    .clk        (clk),
    .write_en   (we),
    .write_addr (waddr),
    .data_in    (wdata),
    .read_addr  (bus.ram_addr),
    .data_out   (bus.ram_data)
  );

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
    bit         last;
  } exp_t;

  exp_t       sb[$];
  int         xfer_cyc[$];
  logic [7:0] model [16];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         n_xfer = 0;
  int         done_seen = 0;
  int         bursts = 0;
  bit         exp_done_next = 0;
  bit         rand_ready = 0;
  logic       prev_valid = 0, prev_ready = 0, prev_abort = 0;
  logic [7:0] prev_data = '0;
  logic [3:0] prev_addr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // monitor: checks every transfer against the scoreboard and the done pulse
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_done_next) begin
        chk("done_pulse", bus.done, 1);
        if (bus.done) done_seen++;
        exp_done_next = 0;
      end else if (bus.done) begin
        chk("stray_done", bus.done, 0);
      end
      if (prev_valid && !prev_ready && !prev_abort && bus.out_valid) begin
        chk("hold_data", bus.out_data, prev_data);
        chk("hold_addr", bus.out_addr, prev_addr);
      end
      if (bus.out_valid && bus.out_ready && !bus.abort) begin
        n_xfer++;
        xfer_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          chk("unexpected_word", bus.out_addr, 32'hFFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("word_data", bus.out_data, e.data);
          chk("word_addr", bus.out_addr, e.addr);
          if (e.last) exp_done_next = 1;
        end
      end
      prev_valid = bus.out_valid;
      prev_ready = bus.out_ready;
      prev_abort = bus.abort;
      prev_data  = bus.out_data;
      prev_addr  = bus.out_addr;
    end else begin
      exp_done_next = 0;
      prev_valid = 0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic write_ram(input logic [3:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    we = 1'b1; waddr = a; wdata = d;
    @(posedge clk); #1;
    we = 1'b0;
    model[a] = d;
  endtask

  task automatic push_burst(input logic [3:0] f, input logic [3:0] l);
    logic [3:0] span;
    int n;
    span = l - f;
    n = int'(span) + 1;
    for (int i = 0; i < n; i++) begin
      logic [3:0] a;
      a = f + 4'(i);
      sb.push_back('{a, model[a], i == n - 1});
    end
    bursts++;
  endtask

  // drives start for exactly one edge; k is the index of that accepting edge
  task automatic do_start(input logic [3:0] f, input logic [3:0] l, output int k);
    bus.first_addr = f;
    bus.last_addr  = l;
    bus.start      = 1'b1;
    @(posedge clk); #1;
    k = cyc;
    bus.start      = 1'b0;
    bus.first_addr = 4'($urandom);
    bus.last_addr  = 4'($urandom);
  endtask

  task automatic wait_done();
    int g = 0;
    while (done_seen < bursts && g < 3000) begin
      @(negedge clk);
      g++;
    end
    chk("burst_complete", done_seen, bursts);
    chk("sb_empty", sb.size(), 0);
  endtask

  task automatic wait_valid();
    int g = 0;
    @(negedge clk);
    while (!bus.out_valid && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("valid_seen", bus.out_valid, 1);
  endtask

  task automatic wait_xfers(input int target);
    int g = 0;
    while (n_xfer < target && g < 500) begin
      @(negedge clk);
      g++;
    end
    chk("xfer_count", n_xfer, target);
  endtask

  task automatic burst_2_5_timed();
    int k, b;
    b = xfer_cyc.size();
    push_burst(4'd2, 4'd5);
    do_start(4'd2, 4'd5, k);
    wait_done();
    for (int i = 0; i < 4; i++)
      chk("latency", xfer_cyc[b + i] - k, 2 + 3 * i);
  endtask

  initial begin
    int k, base;
    bus.start = 0; bus.abort = 0; bus.out_ready = 0;
    bus.first_addr = '0; bus.last_addr = '0;
    for (int i = 0; i < 16; i++) write_ram(4'(i), 8'hA0 + 8'(i));
    chk("rst_ram_addr", bus.ram_addr, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_addr", bus.out_addr, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // basic burst with exact cycle timing
    bus.out_ready = 1'b1;
    burst_2_5_timed();

    // wrapping burst
    push_burst(4'd14, 4'd1);
    do_start(4'd14, 4'd1, k);
    wait_done();

    // single word under backpressure
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    push_burst(4'd7, 4'd7);
    do_start(4'd7, 4'd7, k);
    wait_valid();
    for (int j = 0; j < 6; j++) begin
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_data", bus.out_data, 8'hA7);
      if (j < 5) begin
        @(posedge clk); #1;
        if (j == 4) bus.out_ready = 1'b1;
        @(negedge clk);
      end
    end
    wait_done();

    // full-range burst with a start pulse injected mid-burst
    base = n_xfer;
    push_burst(4'd0, 4'd15);
    do_start(4'd0, 4'd15, k);
    wait_xfers(base + 5);
    @(posedge clk); #1;
    do_start(4'd9, 4'd9, k);
    wait_done();
    chk("xfers_16", n_xfer - base, 16);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_after_full", bus.busy, 0);
    chk("no_restart_valid", bus.out_valid, 0);

    // abort on the third word while out_ready is high
    base = n_xfer;
    sb.push_back('{4'd0, model[0], 1'b0});
    sb.push_back('{4'd1, model[1], 1'b0});
    do_start(4'd0, 4'd7, k);
    wait_xfers(base + 2);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    wait_valid();
    chk("abort_word_addr", bus.out_addr, 2);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_valid", bus.out_valid, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("abort_xfers", n_xfer - base, 2);
    chk("abort_sb_empty", sb.size(), 0);

    // RAM write to a not-yet-read address mid-burst; abort in IDLE is ignored
    model[6] = 8'h5C;
    push_burst(4'd3, 4'd6);
    bus.abort = 1'b1;
    do_start(4'd3, 4'd6, k);
    bus.abort = 1'b0;
    we = 1'b1; waddr = 4'd6; wdata = 8'h5C;
    @(posedge clk); #1;
    we = 1'b0;
    wait_done();

    // asynchronous reset in LATCH, then the first burst again from the first edge
    @(posedge clk); #1;
    do_start(4'd2, 4'd5, k);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_ram_addr", bus.ram_addr, 0);
    chk("arst_out_data", bus.out_data, 0);
    chk("arst_out_addr", bus.out_addr, 0);
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done, 0);
    #2;
    rst_n = 1'b1;
    burst_2_5_timed();

    // randomized bursts, RAM contents and backpressure
    rand_ready = 1;
    for (int r = 0; r < 10; r++) begin
      logic [3:0] f, l;
      repeat (3) write_ram(4'($urandom), 8'($urandom));
      f = 4'($urandom);
      l = 4'($urandom);
      push_burst(f, l);
      @(posedge clk); #1;
      do_start(f, l, k);
      wait_done();
    end
    rand_ready = 0;
    repeat (5) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_stream_reader.md
RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the RAM word width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 4, giving the RAM address width (2**ADDR_WIDTH words).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: request a burst read; sampled only in IDLE.
REQ-006 The block SHALL have port abort, input, 1 bit: synchronous cancel of a running burst.
REQ-007 The block SHALL have port first_addr, input, ADDR_WIDTH bits: first address of the burst.
REQ-008 The block SHALL have port last_addr, input, ADDR_WIDTH bits: last address of the burst, inclusive.
REQ-009 The block SHALL have port ram_addr, output, ADDR_WIDTH bits: registered read address to the dual_port_RAM read_addr.
REQ-010 The block SHALL have port ram_data, input, DATA_WIDTH bits: from dual_port_RAM data_out, valid one clock after ram_addr.
REQ-011 The block SHALL have port out_data, output, DATA_WIDTH bits: streamed word.
REQ-012 The block SHALL have port out_addr, output, ADDR_WIDTH bits: address of out_data.
REQ-013 The block SHALL have port out_valid, output, 1 bit: out_data and out_addr valid.
REQ-014 The block SHALL have port out_ready, input, 1 bit: consumer accepts the word.
REQ-015 The block SHALL have port busy, output, 1 bit: burst in progress (state not IDLE).
REQ-016 The block SHALL have port done, output, 1 bit: one-cycle pulse after the last word transfers.

Function
REQ-017 The FSM SHALL have states IDLE, ADDR, LATCH and VALID.
REQ-018 In IDLE with start=1 at edge k, the block SHALL capture first_addr into cur_addr and last_addr into end_addr, drive ram_addr=first_addr, and enter ADDR.
REQ-019 first_addr and last_addr SHALL be ignored outside that capture edge.
REQ-020 ADDR SHALL last one cycle (RAM samples ram_addr at edge k+1) and then enter LATCH.
REQ-021 At the LATCH exit edge (k+2), the block SHALL register ram_data into out_data and cur_addr into out_addr, and enter VALID with out_valid=1.
REQ-022 First-word latency from the start edge to out_valid high SHALL be 2 cycles.
REQ-023 In VALID, out_data and out_addr SHALL hold stable while out_ready=0; out_valid SHALL stay high.
REQ-024 A transfer SHALL occur at any edge with out_valid=1 and out_ready=1.
REQ-025 On a transfer with cur_addr!=end_addr, the block SHALL set cur_addr and ram_addr to cur_addr+1 modulo 2**ADDR_WIDTH, drop out_valid, and enter ADDR (3 cycles per word without backpressure).
REQ-026 On a transfer with cur_addr==end_addr, the block SHALL drop out_valid, enter IDLE and pulse done for exactly one cycle.
REQ-027 If last_addr<first_addr, the burst SHALL wrap through 2**ADDR_WIDTH-1 to 0.
REQ-028 Burst length SHALL be ((last-first) mod 2**ADDR_WIDTH)+1, ranging from 1 to 2**ADDR_WIDTH.
REQ-029 If first==last, the burst SHALL be exactly one word.
REQ-030 start SHALL be ignored while busy=1.
REQ-031 abort=1 in any non-IDLE state SHALL force IDLE at the next edge, with out_valid=0 and no done pulse.
REQ-032 abort SHALL take priority over a simultaneous transfer.
REQ-033 abort in IDLE SHALL have no effect.
REQ-034 The block SHALL never write the RAM.
REQ-035 The block SHALL tolerate RAM writes during a burst: each word shows the RAM contents at its own read edge.

Reset
REQ-036 rst_n=0 SHALL immediately force state IDLE, ram_addr=0, out_data=0, out_addr=0, out_valid=0, busy=0, done=0, cur_addr=0 and end_addr=0, independent of clk.
REQ-037 Reset asserted mid-burst SHALL discard the burst.
REQ-038 After rst_n deasserts, the first start SHALL be accepted on the first rising edge.

Structure
REQ-039 A shared package SHALL hold the state enumeration (2-bit encoding: IDLE=0, ADDR=1, LATCH=2, VALID=3) and the default DATA_WIDTH and ADDR_WIDTH constants.
REQ-040 The block SHALL contain no sub-module.
REQ-041 The test environment SHALL instantiate the existing dual_port_RAM beside the block, with ram_addr driving read_addr and data_out driving ram_data.

Verification
REQ-042 Scenario: preload RAM[i]=8'hA0+i, start with first=2 and last=5, out_ready=1 -> words A2,A3,A4,A5 with out_addr 2..5, out_valid rising 2 cycles after start and then every 3 cycles, one done pulse after A5.
REQ-043 Scenario: first=14, last=1 -> out_addr sequence 14,15,0,1 and done after address 1.
REQ-044 Scenario: first=last=7, with out_ready held low for 5 cycles -> out_data=A7 stable for all 6 valid cycles, exactly one transfer, then done.
REQ-045 Scenario: first=0, last=15 -> 16 words, with a start pulse injected mid-burst that has no effect.
REQ-046 Scenario: abort asserted in VALID on the third word with out_ready=1 -> that word is not transferred, the block is in IDLE with busy=0 on the next cycle, and done is never seen.
REQ-047 Scenario: rst_n asserted low mid-LATCH, asynchronously between edges -> all outputs 0 immediately, and a new start after release reproduces REQ-042.
